addsub_pe_sched: RTL and testbench
==================================

Name: addsub_pe_sched

Overview:
- Round-robin scheduler that shares one AddSubPE instance among N requesters.
- Accepts per-requester add/sub jobs over a valid/ready handshake and drives the PE's operand and mode inputs from registers.
- Tracks in-flight jobs with a tag pipeline matched to the PE latency, and returns each result to its originating requester.
- Sits between the vector/issue logic and the AddSubPE; the PE is instantiated outside this block.

Parameters:
- N, 4, number of requesters (2..8).
- PE_LATENCY, 2, clock cycles from PE input change to the corresponding io_pe_out (0 = combinational PE).
- W, 32, operand/result width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- io_req_valid  in  N  per-requester job valid
- io_req_ready  out  N  per-requester accept; at most one bit high
- io_req_in_0  in  N*W  operand A, requester i at [i*W +: W]
- io_req_in_1  in  N*W  operand B, same packing
- io_req_op  in  N  0=add, 1=sub
- io_req_use_int  in  N  1=INT32, 0=FP32
- io_rounding  in  3  global rounding mode, sampled at accept
- io_tininess  in  1  global tininess mode, sampled at accept
- io_resp_valid  out  N  one-hot result strobe, 1 cycle
- io_resp_data  out  W  result, valid with io_resp_valid
- io_busy  out  1  any job in flight
- io_pe_in_0 / io_pe_in_1  out  W  to PE operands
- io_pe_op, io_pe_use_int, io_pe_tininess  out  1  to PE
- io_pe_rounding  out  3  to PE
- io_pe_out  in  W  from PE result

Behaviour:
- Reset (synchronous): io_req_ready, io_resp_valid and io_busy = 0; all io_pe_* regs = 0; priority pointer = 0; tag pipe cleared. A reset mid-operation drops every in-flight job with no response.
- Arbitration:
  - Grant = first set io_req_valid bit searching from pointer p upward, wrapping N-1 -> 0.
  - io_req_ready is the combinational one-hot of the grant and is never asserted without the matching valid.
  - Accept = valid & ready at a posedge.
  - After accepting requester g, p <= (g+1) mod N. With no accept, p holds.
- Throughput: one accept per cycle with no bubbles; the PE is fully pipelined.
- Issue: on accept, the granted in_0/in_1/op/use_int plus io_rounding/io_tininess are registered into the io_pe_* outputs. With no accept, io_pe_* hold their previous values.
- Tag pipe: shift register of depth PE_LATENCY+1 holding {valid, id}. Stage 0 is loaded on accept (valid=0 otherwise); the stage indexed PE_LATENCY aligns with io_pe_out.
- Response: when the aligned stage is valid, io_resp_data <= io_pe_out and io_resp_valid <= onehot(id), both registered. Total latency from accept edge to io_resp_valid high = PE_LATENCY+2 edges.
- No response backpressure: requesters must accept io_resp_valid.
- io_resp_data holds its last value when no response is valid.
- io_busy = OR of tag pipe valids OR io_resp_valid.
- Simultaneous accept and response in the same cycle is legal and independent.
- Any requester may issue again while its previous job is still in flight; results return in accept order.

Optional Feature:
- Macro: ADDSUB_SCHED_PERF_EN.
- When defined: adds io_perf_conflicts (out, 32). It increments on every cycle where more than one io_req_valid bit is high, saturates at 0xFFFFFFFF, and resets to 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package addsub_pkg holds:
  - OP_ADD=0, OP_SUB=1
  - FMT_FP=0, FMT_INT=1
  - rounding encodings RM_NEAR_EVEN=3'b000 … RM_NEAR_MAXMAG=3'b100
  - typedef for tag entry {valid, id[$clog2(N)-1:0]}
- Sub-module addsub_rr_arb: pure round-robin grant (inputs: valid vector and pointer; outputs: one-hot grant and next pointer). The scheduler owns the pointer register.

Test Plan:
- Single INT: requester 0, in_0=23, in_1=11, op=1, use_int=1, rm=3'b100 -> io_resp_valid=0001, io_resp_data=0x0000000C exactly PE_LATENCY+2 cycles after accept.
- Single FP: requester 2, in_0=0x41B80000 (23.0), in_1=0x41300000 (11.0), op=1, use_int=0, tininess=1 -> io_resp_valid=0100, io_resp_data=0x41400000.
- All valid: all 4 valid held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; responses return in that order, one per cycle, each carrying its requester's correct sum.
- Wrap: after grant to 3, with requesters 0 and 3 valid -> grant 0 next; io_req_ready never has two bits high.
- Mid-flight reset: accept 3 jobs, assert reset for 1 cycle -> no io_resp_valid afterwards, io_busy=0, pointer=0.
- Perf (macro defined): 5 cycles with ≥2 valids plus 3 cycles with one valid -> io_perf_conflicts=5.

Source files
------------

// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the AddSubPE scheduler slice.
//   - Operation and number-format encodings driven onto the PE control pins.
//   - Rounding-mode encodings carried from io_rounding to io_pe_rounding.
//   - Tag entry used by the in-flight tracking pipe: {valid, requester id}.
//     The id field is sized for the largest supported requester count (8),
//     so one tag type serves every legal N.
// -----------------------------------------------------------------------------
package addsub_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   typedef enum logic {
      FMT_FP  = 1'b0,
      FMT_INT = 1'b1
   } fmt_e;

   typedef enum logic [2:0] {
      RM_NEAR_EVEN   = 3'b000,
      RM_TO_ZERO     = 3'b001,
      RM_DOWN        = 3'b010,
      RM_UP          = 3'b011,
      RM_NEAR_MAXMAG = 3'b100
   } rm_e;

   localparam int MAX_REQ = 8;
   localparam int ID_W    = $clog2(MAX_REQ);

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/addsub_rr_arb.sv
// -----------------------------------------------------------------------------
// addsub_rr_arb
// Pure combinational round-robin grant. The caller owns the pointer register.
// Ports:
//   reqValid  in  N      per-requester request
//   rrPtr     in  PTR_W  highest-priority requester this cycle
//   grant     out N      one-hot grant (all zero when nothing is requesting)
//   nextPtr   out PTR_W  requester after the granted one, wrapping N-1 -> 0;
//                        equals rrPtr when nothing is granted
// -----------------------------------------------------------------------------
module addsub_rr_arb #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     reqValid,
   input  logic [PTR_W-1:0] rrPtr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] nextPtr
);

   logic found;

   // The search is split into two passes so the indices stay loop constants:
   // first the requesters at or above the pointer, then the ones below it,
   // which together walk upward from the pointer and wrap around to zero.
   always_comb begin
      grant   = '0;
      nextPtr = rrPtr;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && reqValid[i] && (i >= int'(rrPtr))) begin
            grant[i] = 1'b1;
            found    = 1'b1;
            nextPtr  = (i == N - 1) ? '0 : PTR_W'(i + 1);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && reqValid[i] && (i < int'(rrPtr))) begin
            grant[i] = 1'b1;
            found    = 1'b1;
            nextPtr  = (i == N - 1) ? '0 : PTR_W'(i + 1);
         end
      end
   end

endmodule

// File: rtl/addsub_pe_sched.sv
// -----------------------------------------------------------------------------
// addsub_pe_sched
// Round-robin scheduler sharing one external, fully pipelined AddSubPE among
// N requesters. Jobs are accepted over valid/ready, issued to the PE from
// registers, tracked by a tag pipe matched to PE_LATENCY, and each result is
// returned to its originating requester in accept order.
// Ports:
//   clock, reset                  clock; synchronous active-high reset
//   io_req_valid/ready  [N]       job handshake, ready is one-hot grant
//   io_req_in_0/in_1    [N*W]     operands, requester i at [i*W +: W]
//   io_req_op/use_int   [N]       0=add/1=sub, 1=INT32/0=FP32
//   io_rounding[3], io_tininess   global modes, sampled at accept
//   io_resp_valid [N], io_resp_data [W]  one-cycle one-hot result strobe
//   io_busy                       any job in flight
//   io_pe_*                       registered drive to the PE
//   io_pe_out [W]                 PE result
//   io_perf_conflicts [32]        only with ADDSUB_SCHED_PERF_EN defined:
//                                 saturating count of cycles with >1 valid
// -----------------------------------------------------------------------------
module addsub_pe_sched
   import addsub_pkg::*;
#(
   parameter int N          = 4,
   parameter int PE_LATENCY = 2,
   parameter int W          = 32
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [N-1:0]   io_req_valid,
   output logic [N-1:0]   io_req_ready,
   input  logic [N*W-1:0] io_req_in_0,
   input  logic [N*W-1:0] io_req_in_1,
   input  logic [N-1:0]   io_req_op,
   input  logic [N-1:0]   io_req_use_int,
   input  logic [2:0]     io_rounding,
   input  logic           io_tininess,
   output logic [N-1:0]   io_resp_valid,
   output logic [W-1:0]   io_resp_data,
   output logic           io_busy,
   output logic [W-1:0]   io_pe_in_0,
   output logic [W-1:0]   io_pe_in_1,
   output logic           io_pe_op,
   output logic           io_pe_use_int,
   output logic           io_pe_tininess,
   output logic [2:0]     io_pe_rounding,
   input  logic [W-1:0]   io_pe_out
`ifdef ADDSUB_SCHED_PERF_EN
   ,
   output logic [31:0]    io_perf_conflicts
`endif
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] rrPtr;
   logic [PTR_W-1:0] nextPtr;
   logic [N-1:0]     grant;
   logic             accept;
   logic [W-1:0]     selA;
   logic [W-1:0]     selB;
   logic             selOp;
   logic             selInt;
   logic [ID_W-1:0]  selId;
   tag_t             tagPipe [0:PE_LATENCY];
   tag_t             alignedTag;
   logic [N-1:0]     respOnehot;

   addsub_rr_arb #(
      .N     (N),
      .PTR_W (PTR_W)
   ) rrArb (
      .reqValid (io_req_valid),
      .rrPtr    (rrPtr),
      .grant    (grant),
      .nextPtr  (nextPtr)
   );

   // Ready is the grant itself, held low while reset is asserted so nothing
   // looks accepted on a cycle that the registers are going to discard.
   always_comb begin
      io_req_ready = reset ? '0 : grant;
      accept       = !reset && (grant != '0);
   end

   // Steer the granted requester's job fields with a one-hot mux; the id is
   // what the tag pipe carries back to pick the response strobe.
   always_comb begin
      selA   = '0;
      selB   = '0;
      selOp  = 1'b0;
      selInt = 1'b0;
      selId  = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            selA   = io_req_in_0[i*W +: W];
            selB   = io_req_in_1[i*W +: W];
            selOp  = io_req_op[i];
            selInt = io_req_use_int[i];
            selId  = ID_W'(i);
         end
      end
   end

   // Priority pointer moves just past the winner on every accept and holds
   // otherwise, which is what gives each requester its fair turn.
   always_ff @(posedge clock) begin
      if (reset) begin
         rrPtr <= '0;
      end else if (accept) begin
         rrPtr <= nextPtr;
      end
   end

   // PE operand and mode registers only load on accept, so the PE sees
   // stable inputs between jobs; global modes are captured with the job.
   always_ff @(posedge clock) begin
      if (reset) begin
         io_pe_in_0     <= '0;
         io_pe_in_1     <= '0;
         io_pe_op       <= 1'b0;
         io_pe_use_int  <= 1'b0;
         io_pe_tininess <= 1'b0;
         io_pe_rounding <= '0;
      end else if (accept) begin
         io_pe_in_0     <= selA;
         io_pe_in_1     <= selB;
         io_pe_op       <= selOp;
         io_pe_use_int  <= selInt;
         io_pe_tininess <= io_tininess;
         io_pe_rounding <= io_rounding;
      end
   end

   // Tag pipe: stage 0 loads alongside the PE input registers, and each
   // further stage tracks one PE pipeline stage, so stage PE_LATENCY lines up
   // with the result currently on io_pe_out. Idle cycles push empty tags.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i <= PE_LATENCY; i++) begin
            tagPipe[i] <= '0;
         end
      end else begin
         tagPipe[0].valid <= accept;
         tagPipe[0].id    <= selId;
         for (int i = 1; i <= PE_LATENCY; i++) begin
            tagPipe[i] <= tagPipe[i-1];
         end
      end
   end

   // Decode the aligned tag into the one-hot requester strobe.
   always_comb begin
      alignedTag = tagPipe[PE_LATENCY];
      respOnehot = '0;
      for (int i = 0; i < N; i++) begin
         if (alignedTag.valid && (alignedTag.id == ID_W'(i))) begin
            respOnehot[i] = 1'b1;
         end
      end
   end

   // Response register: the strobe lasts exactly one cycle per job, while the
   // data register keeps the last result so consumers may sample it late.
   always_ff @(posedge clock) begin
      if (reset) begin
         io_resp_valid <= '0;
         io_resp_data  <= '0;
      end else begin
         io_resp_valid <= respOnehot;
         if (alignedTag.valid) begin
            io_resp_data <= io_pe_out;
         end
      end
   end

   // Busy covers every job from its accept edge until its response strobe
   // has been presented.
   always_comb begin
      io_busy = |io_resp_valid;
      for (int i = 0; i <= PE_LATENCY; i++) begin
         io_busy = io_busy | tagPipe[i].valid;
      end
   end

`ifdef ADDSUB_SCHED_PERF_EN
   logic multiValid;

   // More than one bit set exactly when clearing the lowest set bit leaves
   // something behind.
   always_comb begin
      multiValid = (io_req_valid & (io_req_valid - N'(1))) != '0;
   end

   // Contention counter: counts cycles with competing requests and sticks at
   // all-ones rather than wrapping back to a misleadingly small value.
   always_ff @(posedge clock) begin
      if (reset) begin
         io_perf_conflicts <= '0;
      end else if (multiValid && (io_perf_conflicts != 32'hFFFF_FFFF)) begin
         io_perf_conflicts <= io_perf_conflicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_addsub_pe_sched.sv
// -----------------------------------------------------------------------------
// tb_addsub_pe_sched
// Bench for addsub_pe_sched with N=4, PE_LATENCY=2, W=32. A stand-in PE with
// two register stages closes the loop. The reference keeps a queue of
// accepted jobs with the cycle each response is due, a round-robin pointer,
// and the expected PE register contents.
// Build with ADDSUB_SCHED_PERF_EN defined to also cover io_perf_conflicts.
// -----------------------------------------------------------------------------
module tb_addsub_pe_sched;
   import addsub_pkg::*;

   localparam int N = 4;
   localparam int L = 2;
   localparam int W = 32;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   io_req_valid;
   logic [N-1:0]   io_req_ready;
   logic [N*W-1:0] io_req_in_0;
   logic [N*W-1:0] io_req_in_1;
   logic [N-1:0]   io_req_op;
   logic [N-1:0]   io_req_use_int;
   logic [2:0]     io_rounding;
   logic           io_tininess;
   logic [N-1:0]   io_resp_valid;
   logic [W-1:0]   io_resp_data;
   logic           io_busy;
   logic [W-1:0]   io_pe_in_0;
   logic [W-1:0]   io_pe_in_1;
   logic           io_pe_op;
   logic           io_pe_use_int;
   logic           io_pe_tininess;
   logic [2:0]     io_pe_rounding;
   logic [W-1:0]   io_pe_out;
`ifdef ADDSUB_SCHED_PERF_EN
   logic [31:0]    io_perf_conflicts;
`endif

   addsub_pe_sched #(
      .N          (N),
      .PE_LATENCY (L),
      .W          (W)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .io_req_valid      (io_req_valid),
      .io_req_ready      (io_req_ready),
      .io_req_in_0       (io_req_in_0),
      .io_req_in_1       (io_req_in_1),
      .io_req_op         (io_req_op),
      .io_req_use_int    (io_req_use_int),
      .io_rounding       (io_rounding),
      .io_tininess       (io_tininess),
      .io_resp_valid     (io_resp_valid),
      .io_resp_data      (io_resp_data),
      .io_busy           (io_busy),
      .io_pe_in_0        (io_pe_in_0),
      .io_pe_in_1        (io_pe_in_1),
      .io_pe_op          (io_pe_op),
      .io_pe_use_int     (io_pe_use_int),
      .io_pe_tininess    (io_pe_tininess),
      .io_pe_rounding    (io_pe_rounding),
      .io_pe_out         (io_pe_out)
`ifdef ADDSUB_SCHED_PERF_EN
      ,
      .io_perf_conflicts (io_perf_conflicts)
`endif
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   // Stand-in PE function: exact integer add/sub, the one FP case the bench
   // relies on (23.0 - 11.0 = 12.0), and for other FP jobs a scramble that
   // folds in every control field so any misrouted field changes the result.
   function automatic logic [31:0] peModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic useInt,
                                           input logic [2:0] rmode, input logic tmode);
      if (useInt == FMT_INT) begin
         return (sub == OP_SUB) ? (a - b) : (a + b);
      end
      if ((a == 32'h41B8_0000) && (b == 32'h4130_0000) && (sub == OP_SUB)) begin
         return 32'h4140_0000;
      end
      return (a ^ {b[15:0], b[31:16]}) + {27'd0, sub, tmode, rmode};
   endfunction

   // Stand-in PE pipeline: two register stages, so a result appears two
   // edges after the PE inputs change.
   logic [31:0] peStage1 = '0;
   logic [31:0] peStage2 = '0;
   always @(posedge clock) begin
      peStage1 <= peModel(io_pe_in_0, io_pe_in_1, io_pe_op, io_pe_use_int,
                          io_pe_rounding, io_pe_tininess);
      peStage2 <= peStage1;
   end
   assign io_pe_out = peStage2;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          due;
   } job_t;

   job_t        jobQ[$];
   int          modelPtr;
   int          cycle;
   int          conflictCount;
   logic [31:0] lastData;
   logic [31:0] expPeA;
   logic [31:0] expPeB;
   logic [5:0]  expPeCtrl;
   int          vectors;
   int          miscompares;

   logic [31:0] opA   [N];
   logic [31:0] opB   [N];
   logic        opSub [N];
   logic        opInt [N];
   logic [2:0]  rm;
   logic        tin;

   // Every comparison in the bench goes through here.
   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Round-robin reference: first valid requester at or after the pointer.
   function automatic int modelGrant(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) begin
            return (p + k) % N;
         end
      end
      return -1;
   endfunction

   // Drive one cycle's inputs from the operand arrays.
   task automatic applyStimulus(input logic rst, input logic [N-1:0] valid);
      reset        = rst;
      io_req_valid = valid;
      for (int i = 0; i < N; i++) begin
         io_req_in_0[i*W +: W] = opA[i];
         io_req_in_1[i*W +: W] = opB[i];
         io_req_op[i]          = opSub[i];
         io_req_use_int[i]     = opInt[i];
      end
      io_rounding = rm;
      io_tininess = tin;
   endtask

   // Check the handshake before the edge, advance one cycle, update the
   // reference, then check everything registered.
   task automatic checkOutput();
      int          g;
      logic [N-1:0] expReady;
      logic [N-1:0] expValid;
      logic [31:0] expData;
      #1;
      g        = reset ? -1 : modelGrant(io_req_valid, modelPtr);
      expReady = '0;
      if (g >= 0) expReady[g] = 1'b1;
      check("ready", 32'(io_req_ready), 32'(expReady));
      check("readyOnehot", 32'($onehot0(io_req_ready)), 32'd1);
      if (reset) begin
         conflictCount = 0;
      end else if ($countones(io_req_valid) > 1) begin
         conflictCount++;
      end
      @(posedge clock);
      @(negedge clock);
      cycle++;
      if (reset) begin
         jobQ.delete();
         modelPtr  = 0;
         lastData  = '0;
         expPeA    = '0;
         expPeB    = '0;
         expPeCtrl = '0;
      end else if (g >= 0) begin
         jobQ.push_back('{id: g,
                          data: peModel(opA[g], opB[g], opSub[g], opInt[g], rm, tin),
                          due: cycle + L + 1});
         modelPtr  = (g + 1) % N;
         expPeA    = opA[g];
         expPeB    = opB[g];
         expPeCtrl = {opSub[g], opInt[g], tin, rm};
      end
      check("peIn0", io_pe_in_0, expPeA);
      check("peIn1", io_pe_in_1, expPeB);
      check("peCtrl", 32'({io_pe_op, io_pe_use_int, io_pe_tininess, io_pe_rounding}),
            32'(expPeCtrl));
      check("busy", 32'(io_busy), 32'(jobQ.size() > 0));
      expValid = '0;
      expData  = lastData;
      if ((jobQ.size() > 0) && (jobQ[0].due == cycle)) begin
         expValid[jobQ[0].id] = 1'b1;
         expData              = jobQ[0].data;
         void'(jobQ.pop_front());
      end
      check("respValid", 32'(io_resp_valid), 32'(expValid));
      check("respData", io_resp_data, expData);
      lastData = expData;
`ifdef ADDSUB_SCHED_PERF_EN
      check("perfConflicts", io_perf_conflicts, 32'(conflictCount));
`endif
   endtask

   task automatic idle(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         applyStimulus(1'b0, '0);
         checkOutput();
      end
   endtask

   task automatic randomizeOperands(input logic forceInt);
      for (int i = 0; i < N; i++) begin
         opA[i]   = $urandom;
         opB[i]   = $urandom;
         opSub[i] = 1'($urandom);
         opInt[i] = forceInt ? 1'b1 : 1'($urandom);
      end
      rm  = 3'($urandom_range(4, 0));
      tin = 1'($urandom);
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      cycle         = 0;
      modelPtr      = 0;
      conflictCount = 0;
      lastData      = '0;
      expPeA        = '0;
      expPeB        = '0;
      expPeCtrl     = '0;
      randomizeOperands(1'b0);

      // Reset state.
      applyStimulus(1'b1, '0);
      checkOutput();
      applyStimulus(1'b1, '0);
      checkOutput();

      // Single INT job from requester 0: 23 - 11.
      opA[0] = 32'd23; opB[0] = 32'd11; opSub[0] = OP_SUB; opInt[0] = FMT_INT;
      rm = RM_NEAR_MAXMAG; tin = 1'b0;
      applyStimulus(1'b0, 4'b0001);
      checkOutput();
      idle(5);
      check("intResult", io_resp_data, 32'h0000_000C);

      // Single FP job from requester 2: 23.0 - 11.0 with tininess set.
      opA[2] = 32'h41B8_0000; opB[2] = 32'h4130_0000; opSub[2] = OP_SUB;
      opInt[2] = FMT_FP; rm = RM_NEAR_EVEN; tin = 1'b1;
      applyStimulus(1'b0, 4'b0100);
      checkOutput();
      idle(5);
      check("fpResult", io_resp_data, 32'h4140_0000);

      // All four valid for eight cycles straight out of reset.
      applyStimulus(1'b1, '0);
      checkOutput();
      randomizeOperands(1'b1);
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b0, 4'b1111);
         checkOutput();
      end

      // Wrap: last grant went to 3, so with 0 and 3 valid requester 0 wins.
      applyStimulus(1'b0, 4'b1001);
      checkOutput();
      idle(6);

      // Mid-flight reset drops three accepted jobs; pointer returns to 0.
      randomizeOperands(1'b0);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 4'b0111);
         checkOutput();
      end
      applyStimulus(1'b1, '0);
      checkOutput();
      idle(6);
      applyStimulus(1'b0, 4'b1111);
      checkOutput();
      idle(6);

      // Contention count: five contended cycles then three single-valid ones.
      applyStimulus(1'b1, '0);
      checkOutput();
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b0, (c % 2 == 0) ? 4'b0011 : 4'b1110);
         checkOutput();
      end
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 4'b0100);
         checkOutput();
      end
`ifdef ADDSUB_SCHED_PERF_EN
      check("perfFive", io_perf_conflicts, 32'd5);
`endif
      idle(6);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 400; c++) begin
         randomizeOperands(1'b0);
         applyStimulus(($urandom_range(63, 0) == 0), 4'($urandom));
         checkOutput();
      end
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
